// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : PC register and one-entry instruction buffer placed between the
//            icache and decode; applies redirects to the fetch stream.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  input  logic [63:0] rdata,
  input  logic        inst_update,
  output logic        mem_finish,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  logic [31:0] pc;
  logic        redir_pend;
  logic [31:0] redir_target;

  logic        discard;
  logic        accept;
  logic        load;
  logic [31:0] redirect_aligned;
  logic [31:0] sel_inst;

  // The icache indexes its refill with araddr, so it must come straight from
  // the PC register and never from an input.
  assign araddr           = pc;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign discard          = redirect_valid | redir_pend;
  assign accept           = inst_update & (discard | ~out_valid | out_ready);
  assign load             = accept & ~discard;
  assign mem_finish       = accept & ~rst;
  assign sel_inst         = pc[2] ? rdata[63:32] : rdata[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      redir_pend   <= 1'b0;
      redir_target <= 32'h0;
      out_valid    <= 1'b0;
      out_inst     <= 32'h0;
      out_pc       <= 32'h0;
    end else begin
      if (accept) begin
        if (discard) begin
          pc         <= redirect_valid ? redirect_aligned : redir_target;
          redir_pend <= 1'b0;
        end else begin
          pc <= pc + 32'd4;
        end
      end else if (redirect_valid) begin
        // Fetch in flight: remember where to go once the icache finishes.
        redir_pend   <= 1'b1;
        redir_target <= redirect_aligned;
      end

      if (load) begin
        out_inst <= sel_inst;
        out_pc   <= pc;
      end

      // A redirect kills the buffer even if decode handshakes this cycle.
      if (redirect_valid) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
